// File: rtl/svc_sram_axil_if.sv
// svc_sram_axil_if: SRAM command/response stream to AXI-Lite manager bridge.
// One transaction (read or write) is in flight at a time. The command port
// is only ready in IDLE, so a busy bridge simply back-pressures the client.
//
// Handshake semantics (all channels, both sides): a transfer happens on a
// rising clk edge where valid && ready are both high. A valid, once raised,
// stays high with its payload stable until that transfer. A ready may be
// raised or dropped at any time.
module svc_sram_axil_if #(
  parameter int SRAM_ADDR_WIDTH = 16,
  parameter int SRAM_DATA_WIDTH = 16,
  parameter int SRAM_STRB_WIDTH = SRAM_DATA_WIDTH / 8,
  parameter int LSB             = $clog2(SRAM_DATA_WIDTH) - 3,
  parameter int AXIL_ADDR_WIDTH = SRAM_ADDR_WIDTH + LSB,
  parameter int AXIL_DATA_WIDTH = SRAM_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,

  // SRAM command stream
  input  logic                         sram_cmd_valid,
  output logic                         sram_cmd_ready,
  input  logic [SRAM_ADDR_WIDTH-1:0]   sram_cmd_addr,
  input  logic                         sram_cmd_wr_en,
  input  logic [SRAM_DATA_WIDTH-1:0]   sram_cmd_wr_data,
  input  logic [SRAM_STRB_WIDTH-1:0]   sram_cmd_wr_strb,

  // SRAM read response stream and write error pulse
  output logic                         sram_resp_rd_valid,
  input  logic                         sram_resp_rd_ready,
  output logic [SRAM_DATA_WIDTH-1:0]   sram_resp_rd_data,
  output logic                         sram_resp_rd_err,
  output logic                         sram_wr_err,

  // AXI-Lite write address channel
  output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic                         m_axil_awvalid,
  input  logic                         m_axil_awready,

  // AXI-Lite write data channel
  output logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                         m_axil_wvalid,
  input  logic                         m_axil_wready,

  // AXI-Lite write response channel
  input  logic [1:0]                   m_axil_bresp,
  input  logic                         m_axil_bvalid,
  output logic                         m_axil_bready,

  // AXI-Lite read address channel
  output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic                         m_axil_arvalid,
  input  logic                         m_axil_arready,

  // AXI-Lite read data channel
  input  logic [AXIL_DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]                   m_axil_rresp,
  input  logic                         m_axil_rvalid,
  output logic                         m_axil_rready,

  // Debug view of the FSM state (encoding of state_t below)
  output logic [2:0]                   dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RD_RESP = 3'd5
  } state_t;

  state_t                       state_q, state_d;
  // A single byte-address register serves both awaddr and araddr: only one
  // transaction is ever in flight, so the two can never disagree in use.
  logic [AXIL_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXIL_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [AXIL_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                         awvalid_q, awvalid_d;
  logic                         wvalid_q, wvalid_d;
  logic                         bready_q, bready_d;
  logic                         arvalid_q, arvalid_d;
  logic                         rready_q, rready_d;
  logic                         rd_valid_q, rd_valid_d;
  logic [SRAM_DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                         rd_err_q, rd_err_d;
  logic                         wr_err_q, wr_err_d;

  // Next-state and next-output logic for the transaction FSM
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    wr_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (sram_cmd_valid) begin
          // Word address to byte address; upper bits pass through untouched.
          addr_d = AXIL_ADDR_WIDTH'(sram_cmd_addr) << LSB;
          if (sram_cmd_wr_en) begin
            wdata_d   = sram_cmd_wr_data;
            wstrb_d   = sram_cmd_wr_strb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end

      WR: begin
        // AW and W retire independently; either may finish first or both
        // in the same cycle.
        if (m_axil_awready) awvalid_d = 1'b0;
        if (m_axil_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (m_axil_bvalid) begin
          bready_d = 1'b0;
          wr_err_d = (m_axil_bresp != 2'b00);
          state_d  = IDLE;
        end
      end

      RD_ADDR: begin
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (m_axil_rvalid) begin
          rready_d   = 1'b0;
          rd_data_d  = m_axil_rdata;
          rd_err_d   = (m_axil_rresp != 2'b00);
          rd_valid_d = 1'b1;
          state_d    = RD_RESP;
        end
      end

      RD_RESP: begin
        // Data and error stay frozen until the client takes the response.
        if (sram_resp_rd_ready) begin
          rd_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign sram_cmd_ready     = (state_q == IDLE);
  assign sram_resp_rd_valid = rd_valid_q;
  assign sram_resp_rd_data  = rd_data_q;
  assign sram_resp_rd_err   = rd_err_q;
  assign sram_wr_err        = wr_err_q;

  assign m_axil_awaddr  = addr_q;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_svc_sram_axil_if.sv
// tb_svc_sram_axil_if: bench for the SRAM-to-AXI-Lite manager bridge.
// A behavioural AXI-Lite subordinate with programmable ready delays and
// response codes sits on the manager side, backed by a small word memory.
module tb_svc_sram_axil_if;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int SW  = 2;
  localparam int XAW = 17;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic           sram_cmd_valid, sram_cmd_ready;
  logic [AW-1:0]  sram_cmd_addr;
  logic           sram_cmd_wr_en;
  logic [DW-1:0]  sram_cmd_wr_data;
  logic [SW-1:0]  sram_cmd_wr_strb;
  logic           sram_resp_rd_valid, sram_resp_rd_ready;
  logic [DW-1:0]  sram_resp_rd_data;
  logic           sram_resp_rd_err, sram_wr_err;
  logic [XAW-1:0] m_axil_awaddr, m_axil_araddr;
  logic           m_axil_awvalid, m_axil_awready;
  logic [DW-1:0]  m_axil_wdata, m_axil_rdata;
  logic [SW-1:0]  m_axil_wstrb;
  logic           m_axil_wvalid, m_axil_wready;
  logic [1:0]     m_axil_bresp, m_axil_rresp;
  logic           m_axil_bvalid, m_axil_bready;
  logic           m_axil_arvalid, m_axil_arready;
  logic           m_axil_rvalid, m_axil_rready;
  logic [2:0]     dbg_state;

  svc_sram_axil_if dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .sram_cmd_valid     (sram_cmd_valid),
    .sram_cmd_ready     (sram_cmd_ready),
    .sram_cmd_addr      (sram_cmd_addr),
    .sram_cmd_wr_en     (sram_cmd_wr_en),
    .sram_cmd_wr_data   (sram_cmd_wr_data),
    .sram_cmd_wr_strb   (sram_cmd_wr_strb),
    .sram_resp_rd_valid (sram_resp_rd_valid),
    .sram_resp_rd_ready (sram_resp_rd_ready),
    .sram_resp_rd_data  (sram_resp_rd_data),
    .sram_resp_rd_err   (sram_resp_rd_err),
    .sram_wr_err        (sram_wr_err),
    .m_axil_awaddr      (m_axil_awaddr),
    .m_axil_awvalid     (m_axil_awvalid),
    .m_axil_awready     (m_axil_awready),
    .m_axil_wdata       (m_axil_wdata),
    .m_axil_wstrb       (m_axil_wstrb),
    .m_axil_wvalid      (m_axil_wvalid),
    .m_axil_wready      (m_axil_wready),
    .m_axil_bresp       (m_axil_bresp),
    .m_axil_bvalid      (m_axil_bvalid),
    .m_axil_bready      (m_axil_bready),
    .m_axil_araddr      (m_axil_araddr),
    .m_axil_arvalid     (m_axil_arvalid),
    .m_axil_arready     (m_axil_arready),
    .m_axil_rdata       (m_axil_rdata),
    .m_axil_rresp       (m_axil_rresp),
    .m_axil_rvalid      (m_axil_rvalid),
    .m_axil_rready      (m_axil_rready),
    .dbg_state          (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [34:0] wr_exp_q[$];   // {awaddr, wstrb, wdata} expected per write beat
  logic [16:0] exp_q[$];      // {rd_err, rd_data} expected per read response
  int wr_err_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // ---------------- subordinate model config/state ----------------
  int         aw_delay, w_delay, ar_delay;
  logic [1:0] bresp_cfg, rresp_cfg;
  logic       r_stall;
  int         aw_wait, w_wait, ar_wait;
  logic       aw_fire, w_fire, ar_fire, b_fire, r_fire;
  logic       aw_have, w_have, ar_have;
  logic [XAW-1:0] cap_awaddr, cap_araddr;
  logic [DW-1:0]  cap_wdata;
  logic [SW-1:0]  cap_wstrb;
  logic [DW-1:0]  mem [0:255];
  logic           p_ok, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [XAW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0]  p_wdata;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
    m_axil_bvalid = 0; m_axil_bresp = 0; m_axil_rvalid = 0;
    m_axil_rresp = 0; m_axil_rdata = 0;
  end

  // Subordinate model plus monitors; runs just after each falling edge so
  // DUT outputs and bench-driven inputs have settled for the next rise.
  always @(negedge clk) begin
    logic [16:0] e_rd;
    logic [34:0] e_wr;
    #1;
    if (!rst_n) begin
      m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
      m_axil_bvalid = 0; m_axil_rvalid = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0;
      aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
      aw_have = 0; w_have = 0; ar_have = 0;
      p_ok = 0;
    end else begin
      // AXI stability: a valid that was not accepted must persist unchanged
      if (p_ok) begin
        if (p_awv && !p_awr && (!m_axil_awvalid || m_axil_awaddr !== p_awaddr)) note_fail("aw_unstable");
        if (p_wv && !p_wr && (!m_axil_wvalid || m_axil_wdata !== p_wdata)) note_fail("w_unstable");
        if (p_arv && !p_arr && (!m_axil_arvalid || m_axil_araddr !== p_araddr)) note_fail("ar_unstable");
      end
      if ((m_axil_awvalid || m_axil_wvalid || m_axil_bready) && (m_axil_arvalid || m_axil_rready))
        note_fail("rd_wr_overlap");

      // SRAM read response monitor
      if (sram_resp_rd_valid && sram_resp_rd_ready) begin
        if (exp_q.size() == 0) note_fail("rd_resp_unexpected");
        else begin
          e_rd = exp_q.pop_front();
          check("rd_resp", {sram_resp_rd_err, sram_resp_rd_data}, e_rd);
        end
      end
      if (sram_wr_err) wr_err_cycles++;

      // retire handshakes that completed on the last rising edge
      if (b_fire) begin m_axil_bvalid = 0; b_fire = 0; end
      if (r_fire) begin m_axil_rvalid = 0; r_fire = 0; end
      if (aw_fire) begin aw_have = 1; aw_fire = 0; end
      if (w_fire) begin w_have = 1; w_fire = 0; end
      if (ar_fire) begin ar_have = 1; ar_fire = 0; end

      if (m_axil_awvalid) begin
        m_axil_awready = (aw_wait >= aw_delay);
        aw_wait++;
        if (m_axil_awready) begin aw_fire = 1; cap_awaddr = m_axil_awaddr; end
      end else begin m_axil_awready = 0; aw_wait = 0; end

      if (m_axil_wvalid) begin
        m_axil_wready = (w_wait >= w_delay);
        w_wait++;
        if (m_axil_wready) begin w_fire = 1; cap_wdata = m_axil_wdata; cap_wstrb = m_axil_wstrb; end
      end else begin m_axil_wready = 0; w_wait = 0; end

      if (m_axil_arvalid) begin
        m_axil_arready = (ar_wait >= ar_delay);
        ar_wait++;
        if (m_axil_arready) begin ar_fire = 1; cap_araddr = m_axil_araddr; end
      end else begin m_axil_arready = 0; ar_wait = 0; end

      if (aw_have && w_have && !m_axil_bvalid) begin
        if (wr_exp_q.size() == 0) note_fail("wr_beat_unexpected");
        else begin
          e_wr = wr_exp_q.pop_front();
          check("wr_beat", {cap_awaddr, cap_wstrb, cap_wdata}, e_wr);
        end
        if (bresp_cfg == 2'b00) begin
          if (cap_wstrb[0]) mem[cap_awaddr[8:1]][7:0]  = cap_wdata[7:0];
          if (cap_wstrb[1]) mem[cap_awaddr[8:1]][15:8] = cap_wdata[15:8];
        end
        m_axil_bvalid = 1; m_axil_bresp = bresp_cfg;
        aw_have = 0; w_have = 0;
      end
      if (m_axil_bvalid && m_axil_bready) b_fire = 1;

      if (ar_have && !m_axil_rvalid && !r_stall) begin
        m_axil_rvalid = 1; m_axil_rdata = mem[cap_araddr[8:1]]; m_axil_rresp = rresp_cfg;
        ar_have = 0;
      end
      if (m_axil_rvalid && m_axil_rready) r_fire = 1;

      p_ok = 1;
      p_awv = m_axil_awvalid; p_awr = m_axil_awready; p_awaddr = m_axil_awaddr;
      p_wv = m_axil_wvalid;   p_wr = m_axil_wready;   p_wdata = m_axil_wdata;
      p_arv = m_axil_arvalid; p_arr = m_axil_arready; p_araddr = m_axil_araddr;
    end
  end

  // ---------------- driver tasks ----------------
  // Present a command from a falling edge, hold it until accepted, then drop it.
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
    int t = 0;
    sram_cmd_wr_en = wr; sram_cmd_addr = a; sram_cmd_wr_data = d; sram_cmd_wr_strb = s;
    sram_cmd_valid = 1;
    while (!sram_cmd_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) note_fail("send_cmd_timeout");
    @(negedge clk);
    sram_cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!sram_cmd_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) note_fail("wait_idle_timeout");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    int            awd, wd, ard;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] exp_data;
    logic          exp_err;     // wr_err pulse for writes, rd_err for reads
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int awc, wc, bph, t;
    logic pb;
    int acc [3];
    int e0;

    vec[0]  = '{1'b1, 16'h0012, 16'hBEEF, 2'b11, 0, 0, 0, 2'b00, 2'b00, 16'h0000, 1'b0};
    vec[1]  = '{1'b0, 16'h0012, 16'h0000, 2'b00, 0, 0, 0, 2'b00, 2'b00, 16'hBEEF, 1'b0};
    vec[2]  = '{1'b1, 16'h0034, 16'h1234, 2'b01, 0, 0, 0, 2'b00, 2'b00, 16'h0000, 1'b0};
    vec[3]  = '{1'b0, 16'h0034, 16'h0000, 2'b00, 0, 0, 0, 2'b00, 2'b00, 16'h0034, 1'b0};
    vec[4]  = '{1'b1, 16'h0034, 16'hABCD, 2'b10, 1, 2, 0, 2'b00, 2'b00, 16'h0000, 1'b0};
    vec[5]  = '{1'b0, 16'h0034, 16'h0000, 2'b00, 0, 0, 2, 2'b00, 2'b00, 16'hAB34, 1'b0};
    vec[6]  = '{1'b1, 16'h0034, 16'hFFFF, 2'b00, 0, 0, 0, 2'b00, 2'b00, 16'h0000, 1'b0};
    vec[7]  = '{1'b0, 16'h0034, 16'h0000, 2'b00, 0, 0, 0, 2'b00, 2'b00, 16'hAB34, 1'b0};
    vec[8]  = '{1'b1, 16'hFFFF, 16'h5A5A, 2'b11, 2, 0, 0, 2'b00, 2'b00, 16'h0000, 1'b0};
    vec[9]  = '{1'b0, 16'hFFFF, 16'h0000, 2'b00, 0, 0, 3, 2'b00, 2'b00, 16'h5A5A, 1'b0};
    vec[10] = '{1'b1, 16'h0001, 16'h1111, 2'b11, 0, 3, 0, 2'b00, 2'b00, 16'h0000, 1'b0};
    vec[11] = '{1'b1, 16'h0001, 16'h2222, 2'b11, 0, 0, 0, 2'b10, 2'b00, 16'h0000, 1'b1};
    vec[12] = '{1'b0, 16'h0001, 16'h0000, 2'b00, 0, 0, 0, 2'b00, 2'b11, 16'h1111, 1'b1};
    vec[13] = '{1'b0, 16'h0001, 16'h0000, 2'b00, 0, 0, 0, 2'b00, 2'b00, 16'h1111, 1'b0};

    sram_cmd_valid = 0; sram_cmd_addr = 0; sram_cmd_wr_en = 0;
    sram_cmd_wr_data = 0; sram_cmd_wr_strb = 0; sram_resp_rd_ready = 1;
    aw_delay = 0; w_delay = 0; ar_delay = 0; bresp_cfg = 0; rresp_cfg = 0; r_stall = 0;

    // ---- reset state ----
    rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid,
                       m_axil_rready, sram_resp_rd_valid, sram_wr_err, sram_resp_rd_err}, 8'h00);
    check("rst_regs", {m_axil_awaddr, m_axil_wdata, m_axil_wstrb, sram_resp_rd_data}, 0);
    check("rst_state", dbg_state, 3'd0);
    rst_n = 1;
    @(negedge clk);
    check("idle_ready", sram_cmd_ready, 1'b1);

    // ---- zero-wait write with cycle-exact latency ----
    wr_exp_q.push_back({17'h00024, 2'b11, 16'hBEEF});
    sram_cmd_addr = 16'h0012; sram_cmd_wr_en = 1; sram_cmd_wr_data = 16'hBEEF;
    sram_cmd_wr_strb = 2'b11; sram_cmd_valid = 1;
    @(negedge clk);
    sram_cmd_valid = 0;
    check("wr_n1_valids", {m_axil_awvalid, m_axil_wvalid, sram_cmd_ready}, 3'b110);
    check("wr_awaddr", m_axil_awaddr, 17'h00024);
    check("wr_wdata", {m_axil_wdata, m_axil_wstrb}, {16'hBEEF, 2'b11});
    @(negedge clk);
    check("wr_n2_bready", {m_axil_awvalid, m_axil_wvalid, m_axil_bready}, 3'b001);
    @(negedge clk);
    check("wr_n3_idle", {m_axil_bready, sram_cmd_ready, sram_wr_err}, 3'b010);

    // ---- read back with the response held 5 cycles ----
    sram_resp_rd_ready = 0;
    exp_q.push_back({1'b0, 16'hBEEF});
    sram_cmd_addr = 16'h0012; sram_cmd_wr_en = 0; sram_cmd_valid = 1;
    @(negedge clk);
    sram_cmd_valid = 0;
    check("rd_arvalid", {m_axil_arvalid, sram_cmd_ready}, 2'b10);
    check("rd_araddr", m_axil_araddr, 17'h00024);
    @(negedge clk);
    check("rd_rready", {m_axil_arvalid, m_axil_rready}, 2'b01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("rd_hold%0d", i), {sram_resp_rd_valid, sram_resp_rd_err, sram_resp_rd_data},
            {1'b1, 1'b0, 16'hBEEF});
    end
    sram_resp_rd_ready = 1;
    @(negedge clk);
    check("rd_released", {sram_resp_rd_valid, sram_cmd_ready}, 2'b01);

    // ---- awready delayed 3, wready immediate ----
    aw_delay = 3;
    wr_exp_q.push_back({17'h00080, 2'b11, 16'hC0DE});
    send_cmd(1'b1, 16'h0040, 16'hC0DE, 2'b11);
    awc = 0; wc = 0; bph = 0; t = 0; pb = 0;
    while (!sram_cmd_ready && t < 100) begin
      if (m_axil_awvalid) awc++;
      if (m_axil_wvalid) wc++;
      if (m_axil_bready && !pb) bph++;
      pb = m_axil_bready;
      @(negedge clk);
      t++;
    end
    aw_delay = 0;
    check("slow_aw_timeout", (t < 100), 1'b1);
    check("slow_aw_awvalid_cycles", awc, 4);
    check("slow_aw_wvalid_cycles", wc, 1);
    check("slow_aw_bready_phases", bph, 1);

    // ---- vector table ----
    for (int i = 0; i < NV; i++) begin
      aw_delay = vec[i].awd; w_delay = vec[i].wd; ar_delay = vec[i].ard;
      bresp_cfg = vec[i].bresp; rresp_cfg = vec[i].rresp;
      if (vec[i].wr) wr_exp_q.push_back({vec[i].addr, 1'b0, vec[i].strb, vec[i].data});
      else exp_q.push_back({vec[i].exp_err, vec[i].exp_data});
      e0 = wr_err_cycles;
      send_cmd(vec[i].wr, vec[i].addr, vec[i].data, vec[i].strb);
      wait_idle();
      @(negedge clk);
      if (vec[i].wr) check($sformatf("vec%0d_wr_err", i), wr_err_cycles - e0, 32'(vec[i].exp_err));
    end
    aw_delay = 0; w_delay = 0; ar_delay = 0; bresp_cfg = 0; rresp_cfg = 0;

    // ---- back-to-back read, write, read with valid held high ----
    exp_q.push_back({1'b0, 16'hBEEF});
    wr_exp_q.push_back({17'h00024, 2'b11, 16'h0F0F});
    exp_q.push_back({1'b0, 16'h0F0F});
    sram_cmd_valid = 1;
    for (int i = 0; i < 3; i++) begin
      sram_cmd_wr_en = (i == 1);
      sram_cmd_addr = 16'h0012;
      sram_cmd_wr_data = 16'h0F0F;
      sram_cmd_wr_strb = 2'b11;
      t = 0;
      while (!sram_cmd_ready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) note_fail("b2b_accept_timeout");
      acc[i] = cyc;
      @(negedge clk);
    end
    sram_cmd_valid = 0;
    wait_idle();
    check("b2b_gap_read", acc[1] - acc[0], 4);
    check("b2b_gap_write", acc[2] - acc[1], 3);

    // ---- reset while waiting in RD_DATA ----
    r_stall = 1;
    send_cmd(1'b0, 16'h0040, 16'h0000, 2'b00);
    t = 0;
    while (!m_axil_rready && t < 20) begin @(negedge clk); t++; end
    check("midrst_in_rd_data", {dbg_state, m_axil_rready}, {3'd4, 1'b1});
    #2 rst_n = 0;
    #1;
    check("midrst_outputs", {m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid,
                             m_axil_rready, sram_resp_rd_valid, sram_wr_err}, 7'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    r_stall = 0;
    @(negedge clk);
    check("midrst_after", {sram_cmd_ready, dbg_state}, {1'b1, 3'd0});

    // ---- a normal read after the abandoned one ----
    exp_q.push_back({1'b0, 16'hC0DE});
    send_cmd(1'b0, 16'h0040, 16'h0000, 2'b00);
    wait_idle();
    @(negedge clk);
    @(negedge clk);

    check("rd_exp_drained", exp_q.size(), 0);
    check("wr_exp_drained", wr_exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
